// File: rtl/audio_attenuator.sv
`default_nettype none
// ============================================================================
//  Module      : audio_attenuator
//  Description : Stereo 2x2 gain matrix with one shared multiplier. Each
//                accepted sample pair is processed in four multiply cycles,
//                then saturated to 16 bits and presented with a one-cycle
//                strobe. Gains are double-buffered: shadow writes are
//                committed to the active set at the start of a sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_attenuator (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               sample_strobe,
   input  logic signed [15:0] in_left,
   input  logic signed [15:0] in_right,
   input  logic               att_write,
   input  logic [1:0]         att_sel,
   input  logic [7:0]         att_data,
   input  logic               att_apply,
   input  logic               mute,
   output logic signed [15:0] out_left,
   output logic signed [15:0] out_right,
   output logic               out_strobe,
   output logic               busy,
   output logic               overrun
);

   // Gain matrix indices: 0=LL, 1=LR, 2=RL, 3=RR
   localparam logic [7:0] C_UNITY = 8'h80;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_MUL_LL = 3'd1,
      S_MUL_RL = 3'd2,
      S_MUL_LR = 3'd3,
      S_MUL_RR = 3'd4,
      S_OUT    = 3'd5
   } state_t;

   state_t             r_state;
   logic signed [15:0] r_in_l;
   logic signed [15:0] r_in_r;
   logic [7:0]         r_shadow [4];
   logic [7:0]         r_active [4];
   logic               r_pending;
   logic signed [25:0] r_acc;
   logic signed [25:0] r_sum_l;
   logic signed [15:0] r_out_l;
   logic signed [15:0] r_out_r;
   logic               r_out_strobe;
   logic               r_busy;
   logic               r_overrun;

   logic               w_accept;
   logic               w_first;
   logic signed [15:0] w_mul_in;
   logic [7:0]         w_mul_g;
   logic signed [24:0] w_prod;
   logic signed [25:0] w_sum;

   // Clamp a 26-bit accumulator, after the >>>7 gain scaling, to 16 bits
   function automatic logic signed [15:0] sat16(input logic signed [25:0] v);
      logic signed [25:0] v_sh;
      v_sh = v >>> 7;
      if (v_sh > 26'sd32767)
         sat16 = 16'sh7FFF;
      else if (v_sh < -26'sd32768)
         sat16 = 16'sh8000;
      else
         sat16 = v_sh[15:0];
   endfunction

   // A new sample is taken only when idle or in the output cycle
   assign w_accept = sample_strobe && ((r_state == S_IDLE) || (r_state == S_OUT));

   // First product of each channel starts a fresh accumulation
   assign w_first  = (r_state == S_MUL_LL) || (r_state == S_MUL_LR);

   // Shared multiplier operand selection by FSM state
   always_comb begin
      w_mul_in = w_first ? r_in_l : r_in_r;
      w_mul_g  = 8'h00;
      case (r_state)
         S_MUL_LL: w_mul_g = r_active[0];
         S_MUL_RL: w_mul_g = r_active[2];
         S_MUL_LR: w_mul_g = r_active[1];
         S_MUL_RR: w_mul_g = r_active[3];
         default:  w_mul_g = 8'h00;
      endcase
   end

   // Gain is zero-extended to 9-bit signed, so the product is 16x9 -> 25 bits
   assign w_prod = $signed({{9{w_mul_in[15]}}, w_mul_in}) * $signed({17'd0, w_mul_g});
   assign w_sum  = (w_first ? 26'sd0 : r_acc) + {w_prod[24], w_prod};

   // Shadow gain register writes; independent of the FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shadow[0] <= C_UNITY;
         r_shadow[1] <= 8'h00;
         r_shadow[2] <= 8'h00;
         r_shadow[3] <= C_UNITY;
      end else if (att_write) begin
         r_shadow[att_sel] <= att_data;
      end
   end

   // Sequencer: sample capture, gain commit, multiply-accumulate, output
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_in_l       <= 16'sd0;
         r_in_r       <= 16'sd0;
         r_active[0]  <= C_UNITY;
         r_active[1]  <= 8'h00;
         r_active[2]  <= 8'h00;
         r_active[3]  <= C_UNITY;
         r_pending    <= 1'b0;
         r_acc        <= 26'sd0;
         r_sum_l      <= 26'sd0;
         r_out_l      <= 16'sd0;
         r_out_r      <= 16'sd0;
         r_out_strobe <= 1'b0;
         r_busy       <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_out_strobe <= 1'b0;

         // Commit uses pre-write shadow values, so a coincident write
         // stays in shadow. An apply coinciding with the accept re-arms
         // the flag for the following sample.
         if (w_accept) begin
            if (r_pending) begin
               r_active[0] <= r_shadow[0];
               r_active[1] <= r_shadow[1];
               r_active[2] <= r_shadow[2];
               r_active[3] <= r_shadow[3];
            end
            r_pending <= att_apply;
         end else if (att_apply) begin
            r_pending <= 1'b1;
         end

         if (sample_strobe && r_busy)
            r_overrun <= 1'b1;

         case (r_state)
            S_IDLE, S_OUT: begin
               if (w_accept) begin
                  r_in_l  <= in_left;
                  r_in_r  <= in_right;
                  r_busy  <= 1'b1;
                  r_state <= S_MUL_LL;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_MUL_LL: begin
               r_acc   <= w_sum;
               r_state <= S_MUL_RL;
            end
            S_MUL_RL: begin
               r_sum_l <= w_sum;
               r_state <= S_MUL_LR;
            end
            S_MUL_LR: begin
               r_acc   <= w_sum;
               r_state <= S_MUL_RR;
            end
            S_MUL_RR: begin
               r_out_l      <= mute ? 16'sd0 : sat16(r_sum_l);
               r_out_r      <= mute ? 16'sd0 : sat16(w_sum);
               r_out_strobe <= 1'b1;
               r_busy       <= 1'b0;
               r_state      <= S_OUT;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign out_left   = r_out_l;
   assign out_right  = r_out_r;
   assign out_strobe = r_out_strobe;
   assign busy       = r_busy;
   assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: doc/audio_attenuator.md
AUDIO_ATTENUATOR -- requirements
Module: audio_attenuator

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port sample_strobe, input, 1, one-cycle pulse: in_left/in_right hold a new sample pair.
REQ-004 SHALL have ports in_left and in_right, input, signed 16 each, sample pair from the audio player.
REQ-005 SHALL have ports att_write (input, 1), att_sel (input, 2; 0=LL, 1=LR, 2=RL, 3=RR) and att_data (input, 8), gain shadow-register write.
REQ-006 SHALL have port att_apply, input, 1, pulse requesting commit of shadow gains to active gains.
REQ-007 SHALL have port mute, input, 1, forces zero output while high.
REQ-008 SHALL have ports out_left and out_right, output, signed 16 each, attenuated sample pair.
REQ-009 SHALL have port out_strobe, output, 1, one-cycle pulse: new out_left/out_right valid.
REQ-010 SHALL have ports busy (output, 1, FSM not IDLE) and overrun (output, 1, sticky dropped-sample flag).

Function
REQ-011 SHALL treat gains as unsigned 8-bit; 0x80 = unity, 0x00 = silence, 0xFF ≈ 1.99.
REQ-012 SHALL compute out_left = sat16((in_left*g_LL + in_right*g_RL) >>> 7) and out_right = sat16((in_left*g_LR + in_right*g_RR) >>> 7).
REQ-013 SHALL zero-extend gains to 9-bit signed, form 25-bit products, accumulate in 26 bits, arithmetic-shift right by 7 (floor, no rounding), then clamp to [-32768, 32767].
REQ-014 SHALL use one shared multiplier sequenced by FSM states IDLE -> MUL_LL -> MUL_RL -> MUL_LR -> MUL_RR -> OUT -> IDLE, one cycle per state.
REQ-015 SHALL leave IDLE only on sample_strobe, latching in_left/in_right in that cycle.
REQ-016 SHALL, in OUT, register out_left/out_right and pulse out_strobe high for exactly one cycle.
REQ-017 SHALL give a fixed latency: sample_strobe in cycle N gives out_strobe high in cycle N+5.
REQ-018 SHALL drive busy high in cycles N+1..N+4.
REQ-019 SHALL accept a new sample_strobe again in cycle N+5.
REQ-020 SHALL, on sample_strobe while busy, drop the sample, keep the in-flight computation intact, and set overrun; overrun clears only on reset.
REQ-021 SHALL write att_data to the shadow register selected by att_sel when att_write is high; active gains are unaffected.
REQ-022 SHALL set a pending flag on att_apply.
REQ-023 SHALL, when IDLE accepts a sample_strobe with the pending flag set, copy all four shadow gains to active gains before that sample's computation and clear the flag.
REQ-024 SHALL, when att_apply coincides with an accepted sample_strobe, commit on the next accepted sample.
REQ-025 SHALL, when att_write coincides with a commit, exclude that write from the commit (it stays in shadow).
REQ-026 SHALL, when att_write and att_apply coincide in a non-commit cycle, include the write in the pending commit.
REQ-027 SHALL never change active gains during MUL_* states.
REQ-028 SHALL sample mute in the OUT state; if high, out_left = out_right = 0 while out_strobe still pulses.

Reset
REQ-029 SHALL, on reset_n low, immediately enter IDLE with out_left = out_right = 0, out_strobe = 0, busy = 0, overrun = 0, pending flag = 0.
REQ-030 SHALL reset active and shadow gains to LL = RR = 0x80 and LR = RL = 0x00 (stereo passthrough).
REQ-031 SHALL abort any in-flight computation on reset without producing out_strobe.

Verification
REQ-032 SHALL pass: after reset, in_left = 1000, in_right = -2000, strobe at cycle N -> out_strobe at N+5 with out_left = 1000, out_right = -2000.
REQ-033 SHALL pass: write LL = RR = 0x00, LR = RL = 0x80, send one sample without apply -> unchanged passthrough; pulse apply, next sample (1000, -2000) -> out_left = -2000, out_right = 1000.
REQ-034 SHALL pass: LL = RL = 0xFF, applied; inputs (32767, 32767) -> out_left = 32767; inputs (-32768, -32768) -> out_left = -32768.
REQ-035 SHALL pass: LL = 0x40, RL = 0x00, in_left = -3 -> out_left = -2 (floor of -1.5).
REQ-036 SHALL pass: strobes at N and N+2 -> exactly one out_strobe (N+5, first sample's values) and overrun = 1; strobe at N+5 is accepted.
REQ-037 SHALL pass: reset_n low in cycle N+3 of a computation -> no out_strobe, outputs 0, gains at default, overrun = 0.
